// File: rtl/general_pack.sv
// Shared helpers for the Avalon-ST blocks: width math, ratio legality check
// and the width-reducer state type.
package general_pack;

  // Bits needed to index x items; never less than 1.
  function automatic int log2up_func(input int x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction

  function automatic bit is_pow2_func(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  typedef enum logic {EMPTY, HOLD} reducer_state_t;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST bundle: little-endian symbol order, empty counts unused high lanes.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 4
);
  localparam int EW = general_pack::log2up_func(DATA_WIDTH_IN_BYTES);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             ready;
  logic                             sop;
  logic                             eop;
  logic [EW-1:0]                    empty;

  modport master (output data, valid, sop, eop, empty, input ready);
  modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/avalon_st_slice_mux.sv
// Picks OUT_BYTES-wide sub-beat sel out of a wide word; sub-beat 0 is lowest.
module avalon_st_slice_mux
  import general_pack::*;
#(
  parameter int IN_BYTES  = 16,
  parameter int OUT_BYTES = 4,
  localparam int RATIO    = IN_BYTES / OUT_BYTES,
  localparam int SW       = log2up_func(RATIO)
) (
  input  logic [8*IN_BYTES-1:0]  data,
  input  logic [SW-1:0]          sel,
  output logic [8*OUT_BYTES-1:0] slice
);
  logic [RATIO-1:0][8*OUT_BYTES-1:0] lanes;

  assign lanes = data;
  assign slice = lanes[sel];
endmodule

// File: rtl/avalon_st_width_reducer.sv
// Avalon-ST down-converter: one wide beat -> up to RATIO narrow sub-beats.
// Optional SVA protocol checks under AVALON_WIDTH_REDUCER_ASSERT_EN.
module avalon_st_width_reducer
  import general_pack::*;
#(
  parameter int IN_BYTES  = 16,
  parameter int OUT_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  avalon_st_if.slave  in_st,
  avalon_st_if.master out_st
);
  localparam int RATIO = IN_BYTES / OUT_BYTES;
  localparam int SW    = log2up_func(RATIO);
  localparam int OEW   = log2up_func(OUT_BYTES);

  if (RATIO < 2 || !is_pow2_func(RATIO) || (IN_BYTES % OUT_BYTES) != 0) begin : g_bad_ratio
    $error("avalon_st_width_reducer: IN_BYTES/OUT_BYTES must be a power of two >= 2");
  end

  reducer_state_t        state, state_nxt;
  logic [SW-1:0]         sub_idx, last_idx, acc_last;
  logic [OEW-1:0]        held_pad, acc_pad;
  logic [8*IN_BYTES-1:0] held_data;
  logic                  held_sop, held_eop;
  logic [8*OUT_BYTES-1:0] slice;
  logic                  at_last, in_ready, accept, adv, out_eop;

  // Last sub-beat index and its pad bytes are fixed once, at accept time.
  always_comb begin
    int nb;
    int nsub;
    nb       = IN_BYTES - int'(in_st.empty);
    nsub     = (nb + OUT_BYTES - 1) / OUT_BYTES;
    acc_last = SW'(RATIO - 1);
    acc_pad  = '0;
    if (in_st.eop) begin
      acc_last = SW'(nsub - 1);
      acc_pad  = OEW'(nsub * OUT_BYTES - nb);
    end
  end

  assign at_last     = (sub_idx == last_idx);
  assign in_ready    = (state == EMPTY) || (at_last && out_st.ready);
  assign accept      = in_st.valid && in_ready;
  assign adv         = (state == HOLD) && out_st.ready && !at_last;
  assign in_st.ready = in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = HOLD;
    else if (state == HOLD && at_last && out_st.ready)
      state_nxt = EMPTY;
  end

  always_comb begin
    out_eop      = (state == HOLD) && held_eop && at_last;
    out_st.valid = (state == HOLD);
    out_st.data  = (state == HOLD) ? slice : '0;
    out_st.sop   = (state == HOLD) && held_sop && (sub_idx == '0);
    out_st.eop   = out_eop;
    out_st.empty = out_eop ? held_pad : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_data <= '0;
      held_sop  <= 1'b0;
      held_eop  <= 1'b0;
      held_pad  <= '0;
      sub_idx   <= '0;
      last_idx  <= '0;
    end else if (accept) begin
      held_data <= in_st.data;
      held_sop  <= in_st.sop;
      held_eop  <= in_st.eop;
      held_pad  <= acc_pad;
      sub_idx   <= '0;
      last_idx  <= acc_last;
    end else if (adv) begin
      sub_idx <= sub_idx + SW'(1);
    end
  end

  avalon_st_slice_mux #(.IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES)) u_mux (
    .data  (held_data),
    .sel   (sub_idx),
    .slice (slice)
  );

`ifdef AVALON_WIDTH_REDUCER_ASSERT_EN
  logic in_pkt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_pkt <= 1'b0;
    else if (out_st.valid && out_st.ready) begin
      if (out_st.eop)      in_pkt <= 1'b0;
      else if (out_st.sop) in_pkt <= 1'b1;
    end
  end

  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    out_st.valid && !out_st.ready |=> out_st.valid && $stable(out_st.data) &&
      $stable(out_st.sop) && $stable(out_st.eop) && $stable(out_st.empty))
    else $error("out_st payload changed under backpressure");

  a_empty_zero: assert property (@(posedge clk) disable iff (!rst_n)
    out_st.valid && !out_st.eop |-> out_st.empty == '0)
    else $error("out_st.empty nonzero without eop");

  a_no_nested_sop: assert property (@(posedge clk) disable iff (!rst_n)
    out_st.valid && in_pkt |-> !out_st.sop)
    else $error("out_st.sop inside an open packet");

  a_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    in_st.valid && !in_st.ready |=> in_st.valid)
    else $error("in_st.valid dropped without handshake");
`endif

endmodule

// File: tb/tb_avalon_st_width_reducer.sv
// Randomized bench for avalon_st_width_reducer (16 -> 4 bytes) with a
// queue-based sub-beat model and directed literal checks.
module tb_avalon_st_width_reducer;
  import general_pack::*;

  localparam int IB = 16;
  localparam int OB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(IB)) in_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(OB)) out_if ();

  avalon_st_width_reducer #(.IN_BYTES(IB), .OUT_BYTES(OB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_st  (in_if),
    .out_st (out_if)
  );

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        last;
    int          cyc;
  } nb_t;

  nb_t  q[$];
  nb_t  log_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mode = 0;
  int   pidx = 0;
  logic pat[7];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expand one accepted wide beat into the narrow beats it must produce.
  task automatic push_wide(logic [127:0] d, logic s, logic e, logic [3:0] em);
    int nb;
    int n;
    nb = e ? IB - int'(em) : IB;
    n  = (nb + OB - 1) / OB;
    for (int k = 0; k < n; k++) begin
      nb_t x;
      x.data  = d[k*32 +: 32];
      x.sop   = s && (k == 0);
      x.eop   = e && (k == n - 1);
      x.empty = x.eop ? 2'(n * OB - nb) : 2'd0;
      x.last  = (k == n - 1);
      x.cyc   = 0;
      q.push_back(x);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        0: out_if.ready = 1'b1;
        1: out_if.ready = ($urandom_range(0, 3) != 0);
        default: begin
          out_if.ready = (pidx < 7) ? pat[pidx] : 1'b1;
          pidx++;
        end
      endcase
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        continue;
      end
      chk("out_valid", 32'(out_if.valid), 32'(q.size() != 0));
      if (out_if.valid && q.size() != 0) begin
        chk("out_data",  out_if.data,         q[0].data);
        chk("out_sop",   32'(out_if.sop),     32'(q[0].sop));
        chk("out_eop",   32'(out_if.eop),     32'(q[0].eop));
        chk("out_empty", 32'(out_if.empty),   32'(q[0].empty));
      end
      chk("in_ready", 32'(in_if.ready),
          32'(q.size() == 0 || (q[0].last && out_if.ready)));
      if (out_if.valid && out_if.ready && q.size() != 0) begin
        nb_t x;
        x = q.pop_front();
        x.cyc = cyc;
        log_q.push_back(x);
      end
      if (in_if.valid && in_if.ready)
        push_wide(in_if.data, in_if.sop, in_if.eop, in_if.empty);
    end
  end

  task automatic drive_beat(logic [127:0] d, logic s, logic e, logic [3:0] em);
    logic fired;
    int   n;
    in_if.valid = 1'b1;
    in_if.data  = d;
    in_if.sop   = s;
    in_if.eop   = e;
    in_if.empty = em;
    fired = 1'b0;
    n = 0;
    while (!fired && n < 1000) begin
      @(negedge clk);
      fired = in_if.ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("in_handshake", 32'(fired), 32'd1);
  endtask

  task automatic in_idle();
    in_if.valid = 1'b0;
    in_if.sop   = 1'b0;
    in_if.eop   = 1'b0;
    in_if.empty = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [127:0] inc;
  logic [127:0] rd;
  int nvalid, nir, n;

  initial begin
    in_if.valid = 1'b0;
    in_if.data  = '0;
    in_if.sop   = 1'b0;
    in_if.eop   = 1'b0;
    in_if.empty = '0;
    out_if.ready = 1'b1;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++) inc[i*8 +: 8] = 8'(i);

    #3;
    chk("rst_valid", 32'(out_if.valid), 32'd0);
    chk("rst_sop",   32'(out_if.sop),   32'd0);
    chk("rst_eop",   32'(out_if.eop),   32'd0);
    chk("rst_empty", 32'(out_if.empty), 32'd0);
    chk("rst_data",  out_if.data,       32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_if.ready), 32'd1);

    // Full single-beat packet.
    log_q.delete();
    drive_beat(inc, 1'b1, 1'b1, 4'd0);
    in_idle();
    wait_drain();
    chk("t1_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      chk("t1_d0", log_q[0].data, 32'h03020100);
      chk("t1_d1", log_q[1].data, 32'h07060504);
      chk("t1_d2", log_q[2].data, 32'h0B0A0908);
      chk("t1_d3", log_q[3].data, 32'h0F0E0D0C);
      chk("t1_sop", {log_q[0].sop, log_q[1].sop, log_q[2].sop, log_q[3].sop}, 32'b1000);
      chk("t1_eop", {log_q[0].eop, log_q[1].eop, log_q[2].eop, log_q[3].eop}, 32'b0001);
      chk("t1_empty", 32'(log_q[3].empty), 32'd0);
    end

    // 10-byte eop beat.
    log_q.delete();
    drive_beat(inc, 1'b1, 1'b1, 4'd6);
    in_idle();
    wait_drain();
    chk("t2_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("t2_eop",   32'(log_q[2].eop),   32'd1);
      chk("t2_empty", 32'(log_q[2].empty), 32'd2);
      chk("t2_d16",   32'(log_q[2].data[15:0]), 32'h0908);
    end

    // 4-byte packet fits one sub-beat; input ready in the same cycle.
    log_q.delete();
    drive_beat(inc, 1'b1, 1'b1, 4'd12);
    in_idle();
    chk("t3_valid", 32'(out_if.valid), 32'd1);
    chk("t3_sopeop", {out_if.sop, out_if.eop}, 32'b11);
    chk("t3_empty", 32'(out_if.empty), 32'd0);
    chk("t3_in_ready", 32'(in_if.ready), 32'd1);
    wait_drain();
    chk("t3_count", 32'(log_q.size()), 32'd1);

    // Backpressure pattern 1,0,0,1,1,0,1.
    rd = {$urandom, $urandom, $urandom, $urandom};
    drive_beat(rd, 1'b1, 1'b0, 4'd0);
    in_idle();
    pidx = 0;
    mode = 2;
    nvalid = 0;
    nir = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_if.valid) break;
      nvalid++;
      if (in_if.ready) nir++;
    end
    mode = 0;
    @(posedge clk);
    #1;
    chk("t4_valid_cycles", 32'(nvalid), 32'd7);
    chk("t4_in_ready_cycles", 32'(nir), 32'd1);
    wait_drain();

    // Back-to-back 4-beat packet: 16 sub-beats with no bubble.
    log_q.delete();
    for (int b = 0; b < 4; b++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      drive_beat(rd, b == 0, b == 3, 4'd0);
    end
    in_idle();
    wait_drain();
    chk("t5_count", 32'(log_q.size()), 32'd16);
    if (log_q.size() == 16) begin
      chk("t5_span", 32'(log_q[15].cyc - log_q[0].cyc), 32'd15);
      chk("t5_eop",  32'(log_q[15].eop), 32'd1);
    end

    // Reset mid-packet, then a clean restart.
    log_q.delete();
    rd = {$urandom, $urandom, $urandom, $urandom};
    drive_beat(rd, 1'b1, 1'b0, 4'd0);
    in_idle();
    n = 0;
    while (log_q.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    chk("t6_valid_before", 32'(out_if.valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_async", 32'(out_if.valid), 32'd0);
    chk("t6_eop_async", 32'(out_if.eop), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_in_ready", 32'(in_if.ready), 32'd1);
    log_q.delete();
    drive_beat(inc, 1'b1, 1'b1, 4'd0);
    in_idle();
    wait_drain();
    chk("t6_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() != 0) chk("t6_sop", 32'(log_q[0].sop), 32'd1);

    // Random traffic with random backpressure and framing.
    mode = 1;
    for (int b = 0; b < 300; b++) begin
      in_idle();
      wait_cycles($urandom_range(0, 2));
      rd = {$urandom, $urandom, $urandom, $urandom};
      drive_beat(rd, 1'(($urandom_range(0, 3)) == 0), 1'(($urandom_range(0, 2)) == 0),
                 4'($urandom_range(0, 15)));
    end
    in_idle();
    mode = 0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
